// File: rtl/execute_longop_unit.sv
// Shared multi-cycle multiply/divide unit for the RV M-extension ops.
//
// Multiply is shift-add over a 2*XLEN accumulator, retiring MUL_BITS multiplier
// bits per cycle. Divide is restoring division, retiring DIV_BITS quotient bits
// per cycle. Both reuse one accumulator and one operand register. A start
// request is accepted only in idle; divide-by-zero and signed overflow skip the
// iterations and complete one cycle after the start.
//
// Ports:
//   clk     clock
//   rst     synchronous active-low reset
//   enable  start request, sampled in idle only
//   clear   pipeline flush, aborts any in-flight op (wins over enable)
//   op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rdata1  operand A (multiplicand / dividend)
//   rdata2  operand B (multiplier / divisor)
//   busy    unit not idle
//   ready   one-cycle completion pulse
//   result  registered result, held until the next completion
module execute_longop_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 4,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned NMul = XLEN / MUL_BITS;
    localparam int unsigned NDiv = XLEN / DIV_BITS;
    localparam int unsigned NMax = (NMul > NDiv) ? NMul : NDiv;
    localparam int unsigned CntW = $clog2(NMax) + 1;

    if (!(MUL_BITS == 1 || MUL_BITS == 2 || MUL_BITS == 4 || MUL_BITS == 8) ||
        !(DIV_BITS == 1 || DIV_BITS == 2 || DIV_BITS == 4) ||
        (XLEN % MUL_BITS) != 0 || (XLEN % DIV_BITS) != 0 ||
        XLEN <= MUL_BITS || XLEN <= DIV_BITS) begin : g_param_check
        $error("execute_longop_unit: illegal XLEN/MUL_BITS/DIV_BITS combination");
    end

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;     // {hi, multiplier} or {remainder, dividend/quotient}
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Start-time operand preparation
    logic            sign_a_op, sign_b_op, a_neg, b_neg, start_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        sign_a_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sign_b_op = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg     = sign_a_op & rdata1[XLEN-1];
        b_neg     = sign_b_op & rdata2[XLEN-1];
        a_mag     = a_neg ? -rdata1 : rdata1;
        b_mag     = b_neg ? -rdata2 : rdata2;
        // Remainder takes the dividend's sign; products and quotients the xor.
        start_neg = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = (rdata2 == '0);
        div_ovf   = ((op == 3'd4) || (op == 3'd6)) &&
                    (rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (rdata2 == '1);
    end

    // Iteration datapath
    logic [XLEN+MUL_BITS-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_acc, mul_prod, div_acc;
    logic [XLEN-1:0]          mul_res, div_sel, div_res, rem, quo;
    logic [XLEN:0]            rem_ext, diff;

    always_comb begin
        mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                   ({{MUL_BITS{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]});
        mul_acc  = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
        mul_prod = neg_q ? -mul_acc : mul_acc;
        mul_res  = (op_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        rem     = acc_q[2*XLEN-1:XLEN];
        quo     = acc_q[XLEN-1:0];
        rem_ext = '0;
        diff    = '0;
        for (int i = 0; i < int'(DIV_BITS); i++) begin
            rem_ext = {rem, quo[XLEN-1]};
            quo     = {quo[XLEN-2:0], 1'b0};
            // Borrow out of the top bit means the trial subtraction failed.
            diff    = rem_ext - {1'b0, opnd_q};
            if (!diff[XLEN]) begin
                rem    = diff[XLEN-1:0];
                quo[0] = 1'b1;
            end else begin
                rem = rem_ext[XLEN-1:0];
            end
        end
        div_acc = {rem, quo};
        div_sel = op_q[1] ? div_acc[2*XLEN-1:XLEN] : div_acc[XLEN-1:0];
        div_res = neg_q ? -div_sel : div_sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (enable && !clear) begin
                    op_d  = op;
                    neg_d = start_neg;
                    cnt_d = op[2] ? CntW'(NDiv) : CntW'(NMul);
                    if (!op[2]) begin
                        state_d = StMul;
                        opnd_d  = a_mag;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                    end else if (div_zero) begin
                        state_d  = StDone;
                        result_d = op[1] ? rdata1 : '1;
                    end else if (div_ovf) begin
                        state_d  = StDone;
                        result_d = op[1] ? '0 : rdata1;
                    end else begin
                        state_d = StDiv;
                        opnd_d  = b_mag;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                    end
                end
            end
            StMul: begin
                acc_d = mul_acc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d  = StDone;
                    result_d = mul_res;
                end
            end
            StDiv: begin
                acc_d = div_acc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d  = StDone;
                    result_d = div_res;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign ready  = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_execute_longop_unit.sv
module tb_execute_longop_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  opc = 3'd0;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic        busy, rdy;
    logic [31:0] res;

    logic        w_en  = 1'b0;
    logic        w_clr = 1'b0;
    logic [2:0]  w_op  = 3'd0;
    logic [63:0] w_a   = '0;
    logic [63:0] w_b   = '0;
    logic        busy1, rdy1, busy2, rdy2;
    logic [63:0] res1, res2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_longop_unit u_dut (
        .clk(clk), .rst(rst), .enable(en), .clear(clr), .op(opc),
        .rdata1(a), .rdata2(b), .busy(busy), .ready(rdy), .result(res)
    );

    execute_longop_unit #(.XLEN(64), .MUL_BITS(1), .DIV_BITS(2)) u_dut_w1 (
        .clk(clk), .rst(rst), .enable(w_en), .clear(w_clr), .op(w_op),
        .rdata1(w_a), .rdata2(w_b), .busy(busy1), .ready(rdy1), .result(res1)
    );

    execute_longop_unit #(.XLEN(64), .MUL_BITS(8), .DIV_BITS(4)) u_dut_w2 (
        .clk(clk), .rst(rst), .enable(w_en), .clear(w_clr), .op(w_op),
        .rdata1(w_a), .rdata2(w_b), .busy(busy2), .ready(rdy2), .result(res2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: RV M semantics on sign/zero-extended wide integers.
    function automatic logic [63:0] ref_model(input int unsigned xlen, input logic [2:0] o,
                                              input logic [63:0] x, input logic [63:0] y);
        logic [63:0]         mask;
        logic signed [129:0] ux, uy, sx, sy, r, minv;
        logic                ovf;
        mask = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        ux   = {66'd0, x & mask};
        uy   = {66'd0, y & mask};
        sx   = ux[xlen-1] ? ux - (130'sd1 <<< xlen) : ux;
        sy   = uy[xlen-1] ? uy - (130'sd1 <<< xlen) : uy;
        minv = -(130'sd1 <<< (xlen - 1));
        ovf  = (sx == minv) && (sy == -130'sd1);
        case (o)
            3'd0:    r = ux * uy;
            3'd1:    r = (sx * sy) >>> xlen;
            3'd2:    r = (sx * uy) >>> xlen;
            3'd3:    r = (ux * uy) >>> xlen;
            3'd4:    r = (uy == 0) ? -130'sd1 : (ovf ? sx : sx / sy);
            3'd5:    r = (uy == 0) ? -130'sd1 : ux / uy;
            3'd6:    r = (uy == 0) ? ux : (ovf ? 130'sd0 : sx % sy);
            default: r = (uy == 0) ? ux : ux % uy;
        endcase
        return r[63:0] & mask;
    endfunction

    function automatic int exp_latency(input int unsigned xlen, input int unsigned mb,
                                       input int unsigned db, input logic [2:0] o,
                                       input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, minv;
        mask = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        minv = 64'd1 << (xlen - 1);
        if (!o[2]) return int'(xlen / mb) + 1;
        if ((y & mask) == 0) return 1;
        if (!o[0] && (x & mask) == minv && (y & mask) == mask) return 1;
        return int'(xlen / db) + 1;
    endfunction

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        en = 1'b1; opc = o; a = x; b = y;
    endtask

    // Walks the op to completion; with hold, enable stays high and operands churn.
    task automatic finish_op(input bit hold, output logic [31:0] r, output int lat,
                             output int bc);
        r = '0; lat = -1; bc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (hold && lat < 0) begin
                opc = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                en = 1'b0;
            end
            if (busy) bc++;
            if (rdy) begin
                if (lat < 0) begin
                    lat = c; r = res;
                end
                en = 1'b0;
            end
            if (!busy) break;
        end
        en = 1'b0;
    endtask

    task automatic do_dir(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int elat);
        logic [31:0] r;
        int lat, bc;
        @(negedge clk);
        launch(o, x, y);
        finish_op(1'b0, r, lat, bc);
        check_eq(tag, 64'(r), 64'(exp));
        check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
        check_eq({tag, "_busy"}, 64'(bc), 64'(elat));
    endtask

    task automatic run_wide(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        int lat1, lat2;
        logic [63:0] r1, r2;
        lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        w_en = 1'b1; w_op = o; w_a = x; w_b = y;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            w_en = 1'b0;
            if (rdy1 && lat1 < 0) begin lat1 = c; r1 = res1; end
            if (rdy2 && lat2 < 0) begin lat2 = c; r2 = res2; end
            if (lat1 >= 0 && lat2 >= 0) break;
        end
        check_eq("w1_res", r1, ref_model(64, o, x, y));
        check_eq("w1_lat", 64'(lat1), 64'(exp_latency(64, 1, 2, o, x, y)));
        check_eq("w2_res", r2, ref_model(64, o, x, y));
        check_eq("w2_lat", 64'(lat2), 64'(exp_latency(64, 8, 4, o, x, y)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int lat, bc, pulses;
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] wx, wy;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(rdy), 64'd0);
        check_eq("rst_result", 64'(res), 64'd0);
        rst = 1'b1;

        do_dir("mul", 3'd0, 32'd7, 32'd6, 32'd42, 9);
        do_dir("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9);
        do_dir("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
        do_dir("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
        do_dir("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        do_dir("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        do_dir("divu_z", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        do_dir("remu_z", 3'd7, 32'd100, 32'd0, 32'd100, 1);
        do_dir("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_dir("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Clear mid-divide: abort, no pulse, previous result kept.
        do_dir("mul_pre", 3'd0, 32'd7, 32'd6, 32'd42, 9);
        @(negedge clk);
        launch(3'd4, 32'hFFFF_FFEC, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            en = 1'b0;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("clr_busy", 64'(busy), 64'd0);
        check_eq("clr_ready", 64'(rdy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy || busy) pulses++;
        end
        check_eq("clr_no_pulse", 64'(pulses), 64'd0);
        check_eq("clr_result", 64'(res), 64'd42);

        // Enable together with clear must not start.
        launch(3'd0, 32'd3, 32'd3);
        clr = 1'b1;
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        check_eq("enclr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("enclr_busy2", 64'(busy), 64'd0);

        // Back-to-back: enable in the idle cycle right after ready.
        do_dir("b2b_first", 3'd0, 32'd3, 32'd5, 32'd15, 9);
        launch(3'd5, 32'd100, 32'd7);
        finish_op(1'b0, r, lat, bc);
        check_eq("b2b_res", 64'(r), 64'd14);
        check_eq("b2b_lat", 64'(lat), 64'd33);

        // Enable held and operands churning while busy.
        @(negedge clk);
        launch(3'd5, 32'd1000, 32'd7);
        finish_op(1'b1, r, lat, bc);
        check_eq("hold_res", 64'(r), 64'd142);
        check_eq("hold_lat", 64'(lat), 64'd33);
        @(negedge clk);
        check_eq("hold_idle", 64'(busy), 64'd0);

        // Reset mid-multiply.
        launch(3'd0, 32'd9, 32'd9);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_busy", 64'(busy), 64'd0);
        check_eq("mrst_ready", 64'(rdy), 64'd0);
        check_eq("mrst_result", 64'(res), 64'd0);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        check_eq("mrst_no_pulse", 64'(pulses), 64'd0);

        // Random ops on the default configuration.
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom);
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (k % 8 == 3) y = '0;
            if (k % 8 == 5) begin
                o = (k % 16 == 5) ? 3'd4 : 3'd6;
                x = 32'h8000_0000; y = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            launch(o, x, y);
            finish_op(1'b0, r, lat, bc);
            check_eq("rnd_res", 64'(r), ref_model(32, o, 64'(x), 64'(y)));
            check_eq("rnd_lat", 64'(lat), 64'(exp_latency(32, 4, 1, o, 64'(x), 64'(y))));
        end

        // Random ops on the 64-bit sweep configurations.
        for (int k = 0; k < 30; k++) begin
            o  = 3'($urandom);
            wx = {$urandom, $urandom};
            wy = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (k % 8 == 3) wy = '0;
            if (k % 8 == 5) begin
                o  = (k % 16 == 5) ? 3'd4 : 3'd6;
                wx = 64'h8000_0000_0000_0000; wy = '1;
            end
            run_wide(o, wx, wy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
